msk_hpc3_tof_lanes: RTL
=======================

MSK_HPC3_TOF_LANES -- requirements
Module: msk_hpc3_tof_lanes

Interface
REQ-001 SHALL have parameter d, default 2, number of shares (d >= 2).
REQ-002 SHALL have parameter W, default 8, number of independent bit lanes.
REQ-003 SHALL have localparam RND_W = W*d*(d-1), fresh random bits consumed per transaction.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports ina, inb, inc  input  d*W each  sharings; share s of lane k at bit s*W+k.
REQ-007 SHALL have port mode  input  1  0: out = a&b; 1: out = (a&b)^c; sampled with the transaction.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-009 SHALL have ports rnd  input  RND_W  fresh randomness; rnd_valid input 1; rnd_ready output 1.
REQ-010 SHALL have port out  output  d*W  result sharing, same share layout as inputs.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), output handshake.

Function
REQ-012 SHALL compute, per lane, the HPC3 masked product with internal a-delay: u = Reg[a_i*(r0_ij ^ [j2==0]*b_i) ^ [j2==0]*mode*c_i ^ r1_ij], v = Reg[b_j ^ r0_ij], out_i = XOR_j(u_ij) ^ XOR_j(a_prev_i & v_ij).
REQ-013 SHALL register ina internally (a_prev) in the same enabled stage as u/v; no external ina_prev port.
REQ-014 SHALL split rnd per lane into disjoint halves: r0 from the lower W*d(d-1)/2 bits, r1 from the upper half; r0 and r1 SHALL never alias.
REQ-015 SHALL assign in_ready = !out_valid || out_ready (combinational, independent of in_valid and rnd_valid).
REQ-016 SHALL define fire = in_valid && in_ready && rnd_valid; rnd_ready = fire.
REQ-017 SHALL load u, v, a_prev registers only on fire; otherwise hold them bit-exactly (no recomputation with new randomness).
REQ-018 SHALL set out_valid to 1 the cycle after fire; latency exactly 1 cycle.
REQ-019 SHALL clear out_valid when out_ready=1 and no fire occurs in that cycle; fire with out_ready=1 keeps out_valid=1 (back-to-back, one transaction per cycle).
REQ-020 SHALL hold out stable while out_valid=1 and out_ready=0 (stall); in_ready=0 during stall.
REQ-021 SHALL not consume randomness (rnd_ready=0) when in_valid=1 but rnd_valid=0; transaction waits, no state change.
REQ-022 SHALL keep out a function of registers only (no combinational path from inputs to out).

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, clear out_valid, u, v and a_prev to 0, so out = 0 after reset.
REQ-024 SHALL drop any in-flight transaction on reset mid-operation; rnd_ready = 0 while rst_n=0.

Structure
REQ-025 SHALL place the function hpc3_rnd(d) = d*(d-1) and the share/lane index helper in shared package msk_pkg.
REQ-026 SHALL instantiate one sub-module per lane, msk_hpc3_tof_bit (one bit, d shares, enable input), built from bin_AND/bin_XOR/bin_REG/bin_redXOR primitives.
REQ-027 SHALL keep handshake/valid logic in the top module only; lanes contain no control state.

Verification
REQ-028 SHALL cover reset: rst_n=0 two cycles with random inputs -> out_valid=0, out=0, rnd_ready=0.
REQ-029 SHALL cover function d=2,W=1: a=(1,0), b=(0,1), c=(1,1), mode=1, rnd=2'b10 -> next cycle out_valid=1, out[0]^out[1]=1; mode=0 -> 1.
REQ-030 SHALL cover exhaustive d=3, W=2: all a,b,c,mode with random shares/rnd -> unmasked out = (a&b)^(mode&c) every lane.
REQ-031 SHALL cover stall: fire, then out_ready=0 for 5 cycles with changing inputs/rnd -> out unchanged, in_ready=0, rnd_ready=0.
REQ-032 SHALL cover streaming: in_valid=rnd_valid=out_ready=1 for 16 cycles -> 16 consecutive results, one per cycle, in order.
REQ-033 SHALL cover starvation and mid-reset: rnd_valid=0 3 cycles -> no fire; rst_n=0 while out_valid=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/msk_pkg.sv
// rtl/msk_pkg.sv - shared helpers for the masked HPC3 gadgets
package msk_pkg;

  // Fresh random bits per lane for one HPC3 product: d*(d-1).
  function automatic int hpc3_rnd(input int d);
    return d * (d - 1);
  endfunction

  // Bit position of share s of lane k in a d*W wide sharing.
  function automatic int sh_idx(input int s, input int k, input int w);
    return s * w + k;
  endfunction

  // Dense index of the unordered share pair {i, j}, i != j.
  function automatic int pair_idx(input int i, input int j, input int d);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/msk_bin_prims.sv
// rtl/msk_bin_prims.sv - single-bit gate and register primitives for masked gadgets
module bin_AND (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module bin_XOR (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module bin_REG (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);
  logic dout_d;
  logic dout_q;

  always_comb begin
    dout_d = dout_q;
    if (en) dout_d = din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dout_q <= 1'b0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;
endmodule

module bin_redXOR #(
  parameter int N = 2
) (
  input  logic [N-1:0] x,
  output logic         y
);
  assign y = ^x;
endmodule

// File: rtl/msk_hpc3_tof_bit.sv
// rtl/msk_hpc3_tof_bit.sv - one-bit HPC3 masked (a&b)^(mode&c) with registered a
module msk_hpc3_tof_bit
  import msk_pkg::*;
#(
  parameter int D  = 2,
  parameter int NP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [D-1:0]  a,
  input  logic [D-1:0]  b,
  input  logic [D-1:0]  c,
  input  logic          mode,
  input  logic [NP-1:0] r0,
  input  logic [NP-1:0] r1,
  output logic [D-1:0]  out
);

  for (genvar i = 0; i < D; i++) begin : g_sh
    logic [2*D-3:0] terms;
    logic           a_prev;

    bin_REG u_areg (.clk(clk), .rst_n(rst_n), .en(en), .din(a[i]), .dout(a_prev));

    for (genvar jj = 0; jj < D - 1; jj++) begin : g_pr
      localparam int J = (jj < i) ? jj : jj + 1;
      localparam int P = pair_idx(i, J, D);
      logic ar;
      logic u_in;
      logic u_reg;
      logic v_in;
      logic v_reg;

      // The first partner of each share carries the b_i and mode*c_i terms.
      if (jj == 0) begin : g_first
        logic r0b;
        logic mc;
        logic arm;
        bin_XOR x_rb (.a(r0[P]), .b(b[i]), .y(r0b));
        bin_AND a_ar (.a(a[i]), .b(r0b), .y(ar));
        bin_AND a_mc (.a(mode), .b(c[i]), .y(mc));
        bin_XOR x_am (.a(ar), .b(mc), .y(arm));
        bin_XOR x_r1 (.a(arm), .b(r1[P]), .y(u_in));
      end else begin : g_rest
        bin_AND a_ar (.a(a[i]), .b(r0[P]), .y(ar));
        bin_XOR x_r1 (.a(ar), .b(r1[P]), .y(u_in));
      end

      bin_REG u_ureg (.clk(clk), .rst_n(rst_n), .en(en), .din(u_in), .dout(u_reg));
      bin_XOR x_v    (.a(b[J]), .b(r0[P]), .y(v_in));
      bin_REG u_vreg (.clk(clk), .rst_n(rst_n), .en(en), .din(v_in), .dout(v_reg));
      bin_AND a_av   (.a(a_prev), .b(v_reg), .y(terms[D-1+jj]));
      assign terms[jj] = u_reg;
    end

    bin_redXOR #(.N(2*D-2)) u_red (.x(terms), .y(out[i]));
  end

endmodule

// File: rtl/msk_hpc3_tof_lanes.sv
// rtl/msk_hpc3_tof_lanes.sv - W-lane HPC3 masked AND/AND-XOR with valid/ready handshakes
module msk_hpc3_tof_lanes
  import msk_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 8,
  localparam int RND_W = W * hpc3_rnd(d)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [d*W-1:0]   ina,
  input  logic [d*W-1:0]   inb,
  input  logic [d*W-1:0]   inc,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RND_W-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [d*W-1:0]   out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NP = hpc3_rnd(d) / 2;

  logic fire;
  logic out_valid_d;
  logic out_valid_q;

  assign in_ready  = !out_valid_q || out_ready;
  assign fire      = in_valid && in_ready && rnd_valid && rst_n;
  assign rnd_ready = fire;
  assign out_valid = out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    if (fire)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= out_valid_d;
  end

  // r0 occupies the lower half of rnd and r1 the upper half, lane-major.
  for (genvar k = 0; k < W; k++) begin : g_lane
    logic [d-1:0]  a_l;
    logic [d-1:0]  b_l;
    logic [d-1:0]  c_l;
    logic [d-1:0]  o_l;
    logic [NP-1:0] r0_l;
    logic [NP-1:0] r1_l;

    for (genvar s = 0; s < d; s++) begin : g_share
      assign a_l[s] = ina[sh_idx(s, k, W)];
      assign b_l[s] = inb[sh_idx(s, k, W)];
      assign c_l[s] = inc[sh_idx(s, k, W)];
      assign out[sh_idx(s, k, W)] = o_l[s];
    end

    for (genvar p = 0; p < NP; p++) begin : g_rnd
      assign r0_l[p] = rnd[k*NP + p];
      assign r1_l[p] = rnd[W*NP + k*NP + p];
    end

    msk_hpc3_tof_bit #(.D(d), .NP(NP)) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (fire),
      .a    (a_l),
      .b    (b_l),
      .c    (c_l),
      .mode (mode),
      .r0   (r0_l),
      .r1   (r1_l),
      .out  (o_l)
    );
  end

endmodule
